// File: rtl/hello_scroll_ctrl.sv
// hello_scroll_ctrl: one-hot scroll position for the HELLO display, stepped by a
// run-gated prescaler tick or a synchronised, debounced active-low pushbutton.
module hello_scroll_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int DEBOUNCE = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       dir,
    input  logic       step_btn,
    output logic [9:0] hot,
    output logic [3:0] pos,
    output logic       wrap
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    sync_q, sync_d;
    logic [3:0]    pos_q, pos_d;
    logic [9:0]    hot_q, hot_d;
    logic          wrap_q, wrap_d;
    logic          btn_s, tick, press, step, cnt_done;

    assign btn_s    = sync_q[1];
    assign cnt_done = cnt_q == DW'(DEBOUNCE - 1);
    assign tick     = run && presc_q == PW'(TICK_DIV - 1);
    assign step     = tick || press;

    always_comb begin
        sync_d  = {sync_q[0], step_btn};
        presc_d = (!run || tick) ? '0 : presc_q + 1'b1;
        pos_d   = !step ? pos_q :
                  dir   ? (pos_q == 4'd0 ? 4'd9 : pos_q - 4'd1) :
                          (pos_q == 4'd9 ? 4'd0 : pos_q + 4'd1);
        wrap_d  = step && (dir ? pos_q == 4'd0 : pos_q == 4'd9);
        hot_d   = 10'd1 << pos_d;
    end

    // The counter only runs in the two wait states and is zeroed on every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        case (state_q)
            IDLE: if (!btn_s) state_d = PRESS_WAIT;
            PRESS_WAIT: begin
                if (btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press   = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            HELD: if (btn_s) state_d = RELEASE_WAIT;
            RELEASE_WAIT: begin
                if (!btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
            sync_q  <= 2'b11;
            pos_q   <= 4'd0;
            hot_q   <= 10'd1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            sync_q  <= sync_d;
            pos_q   <= pos_d;
            hot_q   <= hot_d;
            wrap_q  <= wrap_d;
        end
    end

    assign hot  = hot_q;
    assign pos  = pos_q;
    assign wrap = wrap_q;
endmodule
